mem_ctrl_queued: RTL and testbench
==================================

// Module: mem_ctrl_queued
// PURPOSE
//  Parametrised, self-contained memory controller model: queued write and read request channels,
//  one shared backing store, tag(=address) returns with 1-cycle ack pulses and configurable read latency.
//  Successor to the single-request, VPI-backed controller; no VPI calls, pure synthesisable-style RTL.
//  Sits between the traffic generators/cache models and the simulated DRAM timing layer.
// PARAMETERS
//  ADDR_W     16   address width; also return tag width
//  DATA_W     16   data word width
//  DEPTH      8    entries per request queue; power of two, >=2
//  RD_LAT     4    read latency in cycles from issue edge, >=1
//  MEM_WORDS  256  backing store words; index = address mod MEM_WORDS (power of two)
// PORTS
//  clk             in   1              clock, all state on rising edge
//  rst_n           in   1              asynchronous active-low reset
//  wr_en           in   1              write request valid
//  wr_address      in   ADDR_W         write address
//  wr_data         in   DATA_W         write data
//  wr_ready        out  1              write queue can accept (count < DEPTH)
//  wr_ret_address  out  ADDR_W         tag of completed write
//  wr_ret_ack      out  1              1-cycle completion pulse for write
//  rd_en           in   1              read request valid
//  rd_address      in   ADDR_W         read address
//  rd_ready        out  1              read queue can accept (count < DEPTH)
//  rd_ret_data     out  DATA_W         read data
//  rd_ret_address  out  ADDR_W         tag of returned read
//  rd_ret_ack      out  1              1-cycle return pulse for read
//  wr_count        out  $clog2(DEPTH+1) write queue occupancy
//  rd_count        out  $clog2(DEPTH+1) read queue occupancy
// BEHAVIOUR
//  - Reset (async, rst_n=0): queues empty, counts 0, ready=1, all ret outputs 0, read pipe cleared,
//    arbiter last_grant=READ. Memory contents NOT cleared (zero at time 0 only). In-flight reads dropped, never acked.
//  - Accept: request accepted at edge A iff en && ready; pushed into its FIFO. en while !ready ignored, no ack.
//  - Issue: at most one request issued to store per edge, only from entries already queued (earliest I=A+1).
//  - Arbiter: both queues non-empty -> grant opposite of last_grant; one non-empty -> grant it; updates last_grant.
//  - Write issue at edge I: mem[addr] <= data; wr_ret_address<=addr, wr_ret_ack<=1 at edge I; ack low next edge unless another write issued.
//  - Read issue at edge I: data sampled from mem at I (sees all writes issued at edges <I); enters RD_LAT-stage pipe;
//    rd_ret_* registered at edge I+RD_LAT-1, ack high exactly one cycle per read. Returns in issue order.
//  - Cross-channel ordering is issue order, not accept order; same-edge accept+issue to same addr impossible.
//  - Simultaneous push and pop on one queue: count unchanged; pointers wrap mod DEPTH.
//  - Full: ready=0 while count==DEPTH; pop on same edge raises ready next cycle (ready is not combinational on pop).
//  - Counts: push-only +1, pop-only -1, both/none hold; never exceed DEPTH or underflow.
//  - ret outputs hold last address/data when ack=0.
// TESTING
//  1 Reset: rst_n=0 mid-run -> all ret outputs 0, counts 0, ready=1 immediately (async); pending read never acks.
//  2 Write 0x0010<-0xBEEF accepted edge 0 -> wr_ret_ack=1, wr_ret_address=0x0010 between edges 1 and 2.
//  3 Read 0x0010 accepted edge 3 (RD_LAT=4) -> rd_ret_ack=1, data=0xBEEF, address=0x0010 between edges 7 and 8.
//  4 Fill: 8 writes with no pop-blocking reads held by stall? -> drive 9 back-to-back writes:
//    wr_count peaks at DEPTH only if issue lags; verify wr_ready=0 at count 8 and 9th request gets no ack.
//  5 Both queues loaded 4 each from reset -> issue order W,R,W,R,W,R,W,R; 4 wr acks, 4 rd acks in order.
//  6 Address 0x0110 aliases 0x0010 (MEM_WORDS=256): write 0x1234 to 0x0110, read 0x0010 -> 0x1234, tag 0x0010.

Source files
------------

// File: rtl/mem_ctrl_queued.sv
// rtl/mem_ctrl_queued.sv - queued write/read memory controller with shared store and pipelined read returns
// Two request FIFOs feed an alternating arbiter; at most one request reaches the store per cycle.
module mem_ctrl_queued #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int DEPTH     = 8,
   parameter int RD_LAT    = 4,
   parameter int MEM_WORDS = 256
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [ADDR_W-1:0]            wr_address,
   input  logic [DATA_W-1:0]            wr_data,
   output logic                         wr_ready,
   output logic [ADDR_W-1:0]            wr_ret_address,
   output logic                         wr_ret_ack,
   input  logic                         rd_en,
   input  logic [ADDR_W-1:0]            rd_address,
   output logic                         rd_ready,
   output logic [DATA_W-1:0]            rd_ret_data,
   output logic [ADDR_W-1:0]            rd_ret_address,
   output logic                         rd_ret_ack,
   output logic [$clog2(DEPTH+1)-1:0]   wr_count,
   output logic [$clog2(DEPTH+1)-1:0]   rd_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int IDX_W = $clog2(MEM_WORDS);

   logic [ADDR_W-1:0] wq_addr [DEPTH];
   logic [DATA_W-1:0] wq_data [DEPTH];
   logic [ADDR_W-1:0] rq_addr [DEPTH];
   logic [PTR_W-1:0]  wq_wp, wq_rp, rq_wp, rq_rp;
   logic [DATA_W-1:0] mem [MEM_WORDS];
   logic              last_grant;   // 1 = last issue was a read
   logic              wr_push, rd_push, issue_wr, issue_rd;
   logic [RD_LAT-1:0] pv;
   logic [DATA_W-1:0] pd [RD_LAT];
   logic [ADDR_W-1:0] pa [RD_LAT];

   assign wr_ready = (wr_count < CNT_W'(DEPTH));
   assign rd_ready = (rd_count < CNT_W'(DEPTH));
   assign wr_push  = wr_en && wr_ready;
   assign rd_push  = rd_en && rd_ready;

   always_comb begin
      issue_wr = 1'b0;
      issue_rd = 1'b0;
      if (wr_count != '0 && rd_count != '0) begin
         issue_wr = last_grant;
         issue_rd = !last_grant;
      end else begin
         issue_wr = (wr_count != '0);
         issue_rd = (rd_count != '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wq_wp    <= '0;
         wq_rp    <= '0;
         rq_wp    <= '0;
         rq_rp    <= '0;
         wr_count <= '0;
         rd_count <= '0;
      end else begin
         if (wr_push)  wq_wp <= wq_wp + PTR_W'(1);
         if (issue_wr) wq_rp <= wq_rp + PTR_W'(1);
         if (rd_push)  rq_wp <= rq_wp + PTR_W'(1);
         if (issue_rd) rq_rp <= rq_rp + PTR_W'(1);
         case ({wr_push, issue_wr})
            2'b10:   wr_count <= wr_count + CNT_W'(1);
            2'b01:   wr_count <= wr_count - CNT_W'(1);
            default: ;
         endcase
         case ({rd_push, issue_rd})
            2'b10:   rd_count <= rd_count + CNT_W'(1);
            2'b01:   rd_count <= rd_count - CNT_W'(1);
            default: ;
         endcase
      end
   end

   // Queue payloads and the backing store are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_push) begin
         wq_addr[wq_wp] <= wr_address;
         wq_data[wq_wp] <= wr_data;
      end
      if (rd_push) rq_addr[rq_wp] <= rd_address;
      if (issue_wr) mem[wq_addr[wq_rp][IDX_W-1:0]] <= wq_data[wq_rp];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant     <= 1'b1;
         wr_ret_ack     <= 1'b0;
         wr_ret_address <= '0;
      end else begin
         wr_ret_ack <= issue_wr;
         if (issue_wr) begin
            wr_ret_address <= wq_addr[wq_rp];
            last_grant     <= 1'b0;
         end
         if (issue_rd) last_grant <= 1'b1;
      end
   end

   // Stage data only advances behind a valid, so the last stage holds the previous return.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pv <= '0;
         for (int k = 0; k < RD_LAT; k++) begin
            pd[k] <= '0;
            pa[k] <= '0;
         end
      end else begin
         pv[0] <= issue_rd;
         if (issue_rd) begin
            pd[0] <= mem[rq_addr[rq_rp][IDX_W-1:0]];
            pa[0] <= rq_addr[rq_rp];
         end
         for (int k = 1; k < RD_LAT; k++) begin
            pv[k] <= pv[k-1];
            if (pv[k-1]) begin
               pd[k] <= pd[k-1];
               pa[k] <= pa[k-1];
            end
         end
      end
   end

   assign rd_ret_ack     = pv[RD_LAT-1];
   assign rd_ret_data    = pd[RD_LAT-1];
   assign rd_ret_address = pa[RD_LAT-1];
endmodule

// File: tb/tb_mem_ctrl_queued.sv
// tb/tb_mem_ctrl_queued.sv - self-checking bench for mem_ctrl_queued
// Directed vector table plus randomized traffic against a queue-based reference model.
module tb_mem_ctrl_queued;
   localparam int DEPTH  = 8;
   localparam int RD_LAT = 4;

   logic        clk, rst_n;
   logic        wr_en, rd_en;
   logic [15:0] wr_address, wr_data, rd_address;
   logic        wr_ready, rd_ready, wr_ret_ack, rd_ret_ack;
   logic [15:0] wr_ret_address, rd_ret_data, rd_ret_address;
   logic [3:0]  wr_count, rd_count;

   mem_ctrl_queued dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data), .wr_ready(wr_ready),
      .wr_ret_address(wr_ret_address), .wr_ret_ack(wr_ret_ack),
      .rd_en(rd_en), .rd_address(rd_address), .rd_ready(rd_ready),
      .rd_ret_data(rd_ret_data), .rd_ret_address(rd_ret_address), .rd_ret_ack(rd_ret_ack),
      .wr_count(wr_count), .rd_count(rd_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Reference model: request queues, a keyed store and a list of scheduled read returns.
   typedef struct { logic [15:0] a; logic [15:0] d; } wreq_t;
   typedef struct { int due; logic [15:0] a; logic [15:0] d; bit k; } rret_t;
   wreq_t       mwq[$];
   logic [15:0] mrq[$];
   rret_t       mret[$];
   logic [15:0] mmem [256];
   bit          mknown [256];
   bit          m_last_rd;
   int          cyc;
   logic        e_wack, e_rack;
   logic [15:0] e_waddr, e_rdata, e_raddr;
   bit          e_rknown;

   task automatic m_reset();
      mwq.delete(); mrq.delete(); mret.delete();
      m_last_rd = 1'b1;
      e_wack = 0; e_waddr = 0; e_rack = 0; e_rdata = 0; e_raddr = 0; e_rknown = 1;
   endtask

   task automatic model_edge(input logic we, input logic [15:0] wa, input logic [15:0] wd,
                             input logic re, input logic [15:0] ra);
      bit gw, gr, wok, rok;
      wreq_t w;
      rret_t r;
      logic [15:0] a;
      if (mwq.size() > 0 && mrq.size() > 0) begin
         gw = m_last_rd; gr = !m_last_rd;
      end else begin
         gw = mwq.size() > 0; gr = mrq.size() > 0;
      end
      wok = we && (mwq.size() < DEPTH);
      rok = re && (mrq.size() < DEPTH);
      e_wack = 0;
      if (gw) begin
         w = mwq.pop_front();
         mmem[w.a[7:0]] = w.d; mknown[w.a[7:0]] = 1;
         e_wack = 1; e_waddr = w.a; m_last_rd = 0;
      end
      if (gr) begin
         a = mrq.pop_front();
         r.due = cyc + RD_LAT - 1; r.a = a; r.d = mmem[a[7:0]]; r.k = mknown[a[7:0]];
         mret.push_back(r);
         m_last_rd = 1;
      end
      if (wok) begin w.a = wa; w.d = wd; mwq.push_back(w); end
      if (rok) mrq.push_back(ra);
      e_rack = 0;
      if (mret.size() > 0 && mret[0].due == cyc) begin
         r = mret.pop_front();
         e_rack = 1; e_rdata = r.d; e_raddr = r.a; e_rknown = r.k;
      end
      cyc++;
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_wack"}, wr_ret_ack, e_wack);
      chk({tag, "_waddr"}, wr_ret_address, e_waddr);
      chk({tag, "_rack"}, rd_ret_ack, e_rack);
      chk({tag, "_raddr"}, rd_ret_address, e_raddr);
      if (e_rknown) chk({tag, "_rdata"}, rd_ret_data, e_rdata);
      chk({tag, "_wcnt"}, wr_count, mwq.size());
      chk({tag, "_rcnt"}, rd_count, mrq.size());
      chk({tag, "_wrdy"}, wr_ready, mwq.size() < DEPTH);
      chk({tag, "_rrdy"}, rd_ready, mrq.size() < DEPTH);
   endtask

   task automatic cycle(input logic we, input logic [15:0] wa, input logic [15:0] wd,
                        input logic re, input logic [15:0] ra);
      wr_en = we; wr_address = wa; wr_data = wd;
      rd_en = re; rd_address = ra;
      model_edge(we, wa, wd, re, ra);
      @(posedge clk); #1;
      wr_en = 0; rd_en = 0;
   endtask

   typedef struct {
      logic wen; logic [15:0] wa; logic [15:0] wd; logic ren; logic [15:0] ra;
      logic xwack; logic [15:0] xwa; logic xrack; logic [15:0] xrd; logic [15:0] xra;
      logic [3:0] xwc; logic [3:0] xrc;
   } vec_t;
   vec_t vt [17];

   initial begin
      int wacks, racks, p;
      bit any_rack, saw_wfull;
      vt[0]  = '{1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 4'd1, 4'd0};
      vt[1]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0010, 1'b0, 16'h0000, 16'h0000, 4'd0, 4'd0};
      vt[2]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0010, 1'b0, 16'h0000, 16'h0000, 4'd0, 4'd0};
      vt[3]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 1'b0, 16'h0010, 1'b0, 16'h0000, 16'h0000, 4'd0, 4'd1};
      vt[4]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0010, 1'b0, 16'h0000, 16'h0000, 4'd0, 4'd0};
      vt[5]  = vt[4];
      vt[6]  = vt[4];
      vt[7]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0010, 1'b1, 16'hBEEF, 16'h0010, 4'd0, 4'd0};
      vt[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0010, 1'b0, 16'hBEEF, 16'h0010, 4'd0, 4'd0};
      vt[9]  = '{1'b1, 16'h0110, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0010, 1'b0, 16'hBEEF, 16'h0010, 4'd1, 4'd0};
      vt[10] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0110, 1'b0, 16'hBEEF, 16'h0010, 4'd0, 4'd0};
      vt[11] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 1'b0, 16'h0110, 1'b0, 16'hBEEF, 16'h0010, 4'd0, 4'd1};
      vt[12] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0110, 1'b0, 16'hBEEF, 16'h0010, 4'd0, 4'd0};
      vt[13] = vt[12];
      vt[14] = vt[12];
      vt[15] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0110, 1'b1, 16'h1234, 16'h0010, 4'd0, 4'd0};
      vt[16] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0110, 1'b0, 16'h1234, 16'h0010, 4'd0, 4'd0};

      cyc = 0;
      rst_n = 0; wr_en = 0; rd_en = 0; wr_address = 0; wr_data = 0; rd_address = 0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_wrdy", wr_ready, 1'b1);
      chk("reset_rrdy", rd_ready, 1'b1);
      chk("reset_wcnt", wr_count, 4'd0);
      chk("reset_rack", rd_ret_ack, 1'b0);
      rst_n = 1;

      // write/read round trip and address aliasing
      for (int i = 0; i < 17; i++) begin
         cycle(vt[i].wen, vt[i].wa, vt[i].wd, vt[i].ren, vt[i].ra);
         chk($sformatf("vec%0d_wack", i), wr_ret_ack, vt[i].xwack);
         chk($sformatf("vec%0d_waddr", i), wr_ret_address, vt[i].xwa);
         chk($sformatf("vec%0d_rack", i), rd_ret_ack, vt[i].xrack);
         chk($sformatf("vec%0d_rdata", i), rd_ret_data, vt[i].xrd);
         chk($sformatf("vec%0d_raddr", i), rd_ret_address, vt[i].xra);
         chk($sformatf("vec%0d_wcnt", i), wr_count, vt[i].xwc);
         chk($sformatf("vec%0d_rcnt", i), rd_count, vt[i].xrc);
      end

      // mid-run async reset with a read in flight
      cycle(0, 0, 0, 1, 16'h0020);
      cycle(1, 16'h0020, 16'h5555, 0, 0);
      cycle(0, 0, 0, 0, 0);
      check_model("prerst");
      rst_n = 0;
      #1;
      chk("arst_wack", wr_ret_ack, 1'b0);
      chk("arst_waddr", wr_ret_address, 16'h0);
      chk("arst_rack", rd_ret_ack, 1'b0);
      chk("arst_rdata", rd_ret_data, 16'h0);
      chk("arst_raddr", rd_ret_address, 16'h0);
      chk("arst_wcnt", wr_count, 4'd0);
      chk("arst_rcnt", rd_count, 4'd0);
      chk("arst_wrdy", wr_ready, 1'b1);
      chk("arst_rrdy", rd_ready, 1'b1);
      @(posedge clk); #1;
      rst_n = 1;
      m_reset();
      any_rack = 0;
      for (int i = 0; i < RD_LAT + 3; i++) begin
         cycle(0, 0, 0, 0, 0);
         if (rd_ret_ack) any_rack = 1;
         check_model("postrst");
      end
      chk("dropped_read_no_ack", any_rack, 1'b0);

      // both queues loaded with four requests each: alternating issue
      wacks = 0; racks = 0;
      for (int i = 0; i < 18; i++) begin
         if (i < 4) cycle(1, 16'h0040 + 16'(i), 16'hA000 + 16'(i), 1, 16'h0040 + 16'(i));
         else cycle(0, 0, 0, 0, 0);
         if (wr_ret_ack) wacks++;
         if (rd_ret_ack) racks++;
         check_model("alt");
      end
      chk("alt_wacks", wacks, 4);
      chk("alt_racks", racks, 4);

      // continuous traffic on both channels until the write queue fills
      saw_wfull = 0;
      for (int i = 0; i < 24; i++) begin
         cycle(1, 16'h0080 + 16'(i), 16'hC000 + 16'(i), 1, 16'h0080 + 16'(i % 4));
         if (wr_count == 4'd8) saw_wfull = 1;
         check_model("fill");
      end
      chk("fill_reached_full", saw_wfull, 1'b1);
      for (int i = 0; i < 24; i++) begin
         cycle(0, 0, 0, 0, 0);
         check_model("drain");
      end

      // randomized traffic at increasing request density
      for (int ph = 0; ph < 4; ph++) begin
         p = 30 + ph * 23;
         for (int i = 0; i < 120; i++) begin
            cycle($urandom_range(0, 99) < p,
                  16'($urandom_range(0, 3) * 256 + $urandom_range(0, 15)), 16'($urandom),
                  $urandom_range(0, 99) < p,
                  16'($urandom_range(0, 3) * 256 + $urandom_range(0, 15)));
            check_model($sformatf("rnd%0d", ph));
         end
      end
      for (int i = 0; i < 30; i++) begin
         cycle(0, 0, 0, 0, 0);
         check_model("tail");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
